// File: rtl/fasttwosum_pkg.sv
// -----------------------------------------------------------------------------
// fasttwosum_pkg
// Shared types for the FastTwoSum merge scheduler: the scheduler state
// encoding and the (sum, error) pair type used for the default FP format
// (E5M2: 1 sign, 5 exponent, 2 mantissa bits).
// -----------------------------------------------------------------------------
package fasttwosum_pkg;

  localparam int unsigned FP_EXP_WIDTH  = 5;
  localparam int unsigned FP_MANT_WIDTH = 2;
  localparam int unsigned FP_BIT_WIDTH  = 1 + FP_EXP_WIDTH + FP_MANT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REDUCE  = 2'd2,
    ST_OUTPUT  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [FP_BIT_WIDTH-1:0] sum;
    logic [FP_BIT_WIDTH-1:0] error;
  } fp_pair_t;

endpackage

// File: rtl/fasttwosum_merge_sched_pool.sv
// -----------------------------------------------------------------------------
// fasttwosum_pair_pool
// Circular FIFO of (sum, error) pairs with one push and up to two pops per
// cycle. The two oldest entries are always visible on head0/head1 so the
// scheduler can issue them without a read latency.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i                 write push_sum_i/push_error_i at the tail
//   pop_i                  number of entries to drop from the head (0..2)
//   head0_*_o, head1_*_o   oldest and second-oldest entries (pre-push view)
//   count_o                current occupancy (0..DEPTH)
//   full_o                 occupancy equals DEPTH
// -----------------------------------------------------------------------------
module fasttwosum_pair_pool
  import fasttwosum_pkg::*;
#(
  parameter int unsigned W     = FP_BIT_WIDTH,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             push_sum_i,
  input  logic [W-1:0]             push_error_i,
  input  logic [1:0]               pop_i,
  output logic [W-1:0]             head0_sum_o,
  output logic [W-1:0]             head0_error_o,
  output logic [W-1:0]             head1_sum_o,
  output logic [W-1:0]             head1_error_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [2*W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_next;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign head_next = head_q + PTR_W'(1);

  assign head0_sum_o   = mem_q[head_q][2*W-1:W];
  assign head0_error_o = mem_q[head_q][W-1:0];
  assign head1_sum_o   = mem_q[head_next][2*W-1:W];
  assign head1_error_o = mem_q[head_next][W-1:0];
  assign count_o       = count_q;
  assign full_o        = (count_q == CNT_W'(DEPTH));

  always_comb begin
    head_d  = head_q + PTR_W'(pop_i);
    tail_d  = push_i ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Storage carries no reset; occupancy tracking decides what is valid.
  // A push into a slot popped in the same cycle is safe because the pop
  // consumed the old contents before this edge.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[tail_q] <= {push_sum_i, push_error_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fasttwosum_merge_sched.sv
// -----------------------------------------------------------------------------
// fasttwosum_merge_sched
// Reduces a variable-length group of (sum, error) pairs to one pair by
// time-sharing a single external fasttwosum_merge unit. Pairs are buffered in
// a FIFO pool; while two or more are present the two oldest are issued, and
// merge results come back to the pool tail after MERGE_LATENCY_I cycles.
// Strict FIFO order fixes the association order, so results are reproducible.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   in_valid_i/in_ready_o            input handshake
//   in_sum_i, in_error_i, in_last_i  input pair, last-of-group marker
//   merge_{sum,error}_{a,b}_o        operands to the merge unit (0 when idle)
//   merge_sum_i, merge_error_i       merge unit result
//   out_valid_o/out_ready_i          output handshake
//   out_sum_o, out_error_o           reduced pair
//   busy_o                           high whenever not IDLE
//
// Optional feature, macro FASTTWOSUM_SCHED_STATS_EN:
//   merge_count_o  merges issued for the current group
//   cycle_count_o  cycles spent in REDUCE (saturating at 16 bits)
// -----------------------------------------------------------------------------
module fasttwosum_merge_sched
  import fasttwosum_pkg::*;
#(
  parameter int unsigned EXP_WIDTH_I     = FP_EXP_WIDTH,
  parameter int unsigned MANT_WIDTH_I    = FP_MANT_WIDTH,
  parameter int unsigned DEPTH_I         = 8,
  parameter int unsigned MERGE_LATENCY_I = 3,
  localparam int unsigned BIT_WIDTH_I    = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
  localparam int unsigned CNT_W          = $clog2(DEPTH_I) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [BIT_WIDTH_I-1:0] in_sum_i,
  input  logic [BIT_WIDTH_I-1:0] in_error_i,
  input  logic                   in_last_i,
  output logic [BIT_WIDTH_I-1:0] merge_sum_a_o,
  output logic [BIT_WIDTH_I-1:0] merge_error_a_o,
  output logic [BIT_WIDTH_I-1:0] merge_sum_b_o,
  output logic [BIT_WIDTH_I-1:0] merge_error_b_o,
  input  logic [BIT_WIDTH_I-1:0] merge_sum_i,
  input  logic [BIT_WIDTH_I-1:0] merge_error_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [BIT_WIDTH_I-1:0] out_sum_o,
  output logic [BIT_WIDTH_I-1:0] out_error_o,
`ifdef FASTTWOSUM_SCHED_STATS_EN
  output logic [CNT_W-1:0]       merge_count_o,
  output logic [15:0]            cycle_count_o,
`endif
  output logic                   busy_o
);

  localparam int unsigned W   = BIT_WIDTH_I;
  localparam int unsigned LAT = MERGE_LATENCY_I;

  sched_state_e state_q, state_d;

  logic             xfer;
  logic             group_end;
  logic             issue;
  logic             retire;
  logic             res_valid;
  logic             push;
  logic [W-1:0]     push_sum;
  logic [W-1:0]     push_error;
  logic [1:0]       pop;
  logic [LAT-1:0]   inflight_q, inflight_d;
  logic [W-1:0]     out_sum_q, out_sum_d;
  logic [W-1:0]     out_error_q, out_error_d;

  logic [W-1:0]     head0_sum, head0_error, head1_sum, head1_error;
  logic [CNT_W-1:0] pool_count;
  logic             pool_full;

  fasttwosum_pair_pool #(
    .W     (W),
    .DEPTH (DEPTH_I)
  ) u_pool (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push),
    .push_sum_i    (push_sum),
    .push_error_i  (push_error),
    .pop_i         (pop),
    .head0_sum_o   (head0_sum),
    .head0_error_o (head0_error),
    .head1_sum_o   (head1_sum),
    .head1_error_o (head1_error),
    .count_o       (pool_count),
    .full_o        (pool_full)
  );

  // Ready depends only on registered state and occupancy.
  assign in_ready_o = (state_q == ST_IDLE) ||
                      ((state_q == ST_COLLECT) && !pool_full);
  assign xfer       = in_valid_i && in_ready_o;

  // The transfer that fills the pool closes the group even without in_last_i.
  assign group_end  = in_last_i || (pool_count == CNT_W'(DEPTH_I - 1));

  assign res_valid  = inflight_q[LAT-1];

  // Input transfers and merge results never coincide: results only return
  // in REDUCE, where the input side is closed.
  assign push       = xfer || res_valid;
  assign push_sum   = xfer ? in_sum_i   : merge_sum_i;
  assign push_error = xfer ? in_error_i : merge_error_i;
  assign pop        = issue ? 2'd2 : (retire ? 2'd1 : 2'd0);

  assign inflight_d = (inflight_q << 1) | LAT'(issue);

  assign merge_sum_a_o   = issue ? head0_sum   : '0;
  assign merge_error_a_o = issue ? head0_error : '0;
  assign merge_sum_b_o   = issue ? head1_sum   : '0;
  assign merge_error_b_o = issue ? head1_error : '0;

  assign out_valid_o = (state_q == ST_OUTPUT);
  assign out_sum_o   = out_sum_q;
  assign out_error_o = out_error_q;
  assign busy_o      = (state_q != ST_IDLE);

  // Next-state logic. The group is finished once a single entry remains and
  // nothing is still travelling through the merge unit.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    retire      = 1'b0;
    out_sum_d   = out_sum_q;
    out_error_d = out_error_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = group_end ? ST_REDUCE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (xfer && group_end) begin
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (pool_count >= CNT_W'(2)) begin
          issue = 1'b1;
        end else if ((pool_count == CNT_W'(1)) && (inflight_q == '0)) begin
          retire      = 1'b1;
          out_sum_d   = head0_sum;
          out_error_d = head0_error;
          state_d     = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clearing the in-flight register on reset makes stale merge results
  // returning after a reset invisible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      inflight_q  <= '0;
      out_sum_q   <= '0;
      out_error_q <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      out_sum_q   <= out_sum_d;
      out_error_q <= out_error_d;
    end
  end

`ifdef FASTTWOSUM_SCHED_STATS_EN
  logic [CNT_W-1:0] merge_count_q, merge_count_d;
  logic [15:0]      cycle_count_q, cycle_count_d;

  // Counters restart with the first transfer of a group and freeze outside
  // REDUCE, so they still hold the group's figures during OUTPUT.
  always_comb begin
    merge_count_d = merge_count_q;
    cycle_count_d = cycle_count_q;
    if ((state_q == ST_IDLE) && xfer) begin
      merge_count_d = '0;
      cycle_count_d = '0;
    end else begin
      if (issue) begin
        merge_count_d = merge_count_q + CNT_W'(1);
      end
      if ((state_q == ST_REDUCE) && (cycle_count_q != 16'hFFFF)) begin
        cycle_count_d = cycle_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      merge_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      merge_count_q <= merge_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign merge_count_o = merge_count_q;
  assign cycle_count_o = cycle_count_q;
`endif

endmodule

// File: tb/tb_fasttwosum_merge_sched.sv
// -----------------------------------------------------------------------------
// tb_fasttwosum_merge_sched
// Drives groups of E5M2 (sum, error) pairs into the scheduler, models the
// external merge unit as a fixed-latency pipeline, and compares the issued
// operand pairs and the reduced output against a queue-based reference that
// reduces the group oldest-first.
// -----------------------------------------------------------------------------
module tb_fasttwosum_merge_sched;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         inValid, inReady, inLast;
  logic [W-1:0] inSum, inError;
  logic [W-1:0] mSumA, mErrA, mSumB, mErrB;
  logic [W-1:0] mSum, mErr;
  logic         outValid, outReady;
  logic [W-1:0] outSum, outError;
  logic         busy;
`ifdef FASTTWOSUM_SCHED_STATS_EN
  logic [$clog2(DEPTH):0] mergeCount;
  logic [15:0]            cycleCount;
`endif

  int nVectors    = 0;
  int nMiscompares = 0;

  logic [15:0] gPairs [DEPTH];
  logic [31:0] issuedQ [$];
  logic [31:0] expIssues [$];
  logic [15:0] expFinal;
  logic [15:0] mergePipe [LAT] = '{default: '0};

  always #5 clk = ~clk;

  fasttwosum_merge_sched dut (
    .clk_i           (clk),
    .rst_ni          (rstN),
    .in_valid_i      (inValid),
    .in_ready_o      (inReady),
    .in_sum_i        (inSum),
    .in_error_i      (inError),
    .in_last_i       (inLast),
    .merge_sum_a_o   (mSumA),
    .merge_error_a_o (mErrA),
    .merge_sum_b_o   (mSumB),
    .merge_error_b_o (mErrB),
    .merge_sum_i     (mSum),
    .merge_error_i   (mErr),
    .out_valid_o     (outValid),
    .out_ready_i     (outReady),
    .out_sum_o       (outSum),
    .out_error_o     (outError),
`ifdef FASTTWOSUM_SCHED_STATS_EN
    .merge_count_o   (mergeCount),
    .cycle_count_o   (cycleCount),
`endif
    .busy_o          (busy)
  );

  // ---------------- E5M2 arithmetic for the merge-unit stand-in -------------
  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic int rne(input real v);
    real f;
    real frac;
    int  fi;
    f    = $floor(v);
    frac = v - f;
    fi   = int'(f);
    if (frac > 0.5) return fi + 1;
    if (frac < 0.5) return fi;
    return (fi % 2 == 0) ? fi : fi + 1;
  endfunction

  function automatic real e5m2ToReal(input logic [7:0] v);
    int  e;
    int  m;
    real mag;
    e = int'(v[6:2]);
    m = int'(v[1:0]);
    if (e == 0) mag = real'(m) * pow2(-16);
    else mag = (1.0 + real'(m) / 4.0) * pow2(e - 15);
    return v[7] ? -mag : mag;
  endfunction

  function automatic logic [7:0] realToE5m2(input real x);
    logic s;
    real  a;
    int   e;
    int   m;
    s = (x < 0.0);
    a = s ? -x : x;
    if (a == 0.0) return {s, 7'd0};
    if (a < pow2(-14)) begin
      m = rne(a / pow2(-16));
      return {s, 7'(m)};
    end
    e = -14;
    while (a >= pow2(e + 1)) e++;
    m = rne((a / pow2(e) - 1.0) * 4.0);
    if (m == 4) begin
      m = 0;
      e++;
    end
    if (e > 15) return {s, 7'h7B};
    return {s, 5'(e + 15), 2'(m)};
  endfunction

  // Merge of (s1,e1) and (s2,e2): rounded sum plus rounded residual.
  function automatic logic [15:0] mergeRef(input logic [15:0] a, input logic [15:0] b);
    real exact;
    real resid;
    logic [7:0] s;
    exact = e5m2ToReal(a[15:8]) + e5m2ToReal(b[15:8]);
    s     = realToE5m2(exact);
    resid = (exact - e5m2ToReal(s)) + e5m2ToReal(a[7:0]) + e5m2ToReal(b[7:0]);
    return {s, realToE5m2(resid)};
  endfunction

  // External merge unit: result appears LAT cycles after the operands.
  always @(posedge clk) begin
    mergePipe[0] <= mergeRef({mSumA, mErrA}, {mSumB, mErrB});
    for (int k = 1; k < LAT; k++) mergePipe[k] <= mergePipe[k-1];
  end
  assign mSum = mergePipe[LAT-1][15:8];
  assign mErr = mergePipe[LAT-1][7:0];

  // Stimulus values are strictly positive, so any real issue is non-zero.
  always @(negedge clk) begin
    if (rstN && ({mSumA, mErrA, mSumB, mErrB} != 32'd0))
      issuedQ.push_back({mSumA, mErrA, mSumB, mErrB});
  end

  // Reference: reduce the group oldest-first, results appended to the tail.
  task automatic computeRef(input int n);
    logic [15:0] work [$];
    logic [15:0] a;
    logic [15:0] b;
    work.delete();
    expIssues.delete();
    for (int i = 0; i < n; i++) work.push_back(gPairs[i]);
    while (work.size() >= 2) begin
      a = work.pop_front();
      b = work.pop_front();
      expIssues.push_back({a, b});
      work.push_back(mergeRef(a, b));
    end
    expFinal = work[0];
  endtask

  task automatic randomPairs(input int n);
    for (int i = 0; i < n; i++) begin
      gPairs[i][15:8] = {1'b0, 5'($urandom_range(18, 12)), 2'($urandom)};
      gPairs[i][7:0]  = ($urandom_range(2, 0) == 0) ? 8'h00
                        : {1'b0, 5'($urandom_range(8, 2)), 2'($urandom)};
    end
  endtask

  // ---------------- drivers (no comparisons) ---------------------------------
  task automatic applyStimulus(input int n, input bit markLast, input int maxGap, output bit ok);
    int gap;
    int waitCnt;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
      inValid = 1'b0;
      repeat (gap) @(negedge clk);
      inValid = 1'b1;
      inSum   = gPairs[i][15:8];
      inError = gPairs[i][7:0];
      inLast  = markLast && (i == n - 1);
      waitCnt = 0;
      while (!inReady && waitCnt < 50) begin
        @(negedge clk);
        waitCnt++;
      end
      if (!inReady) ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic waitOutput(output bit ok);
    int cnt;
    cnt = 0;
    while (!outValid && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    ok = outValid;
  endtask

  task automatic acceptOutput(input int delay);
    repeat (delay) @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
  endtask

  // ---------------- tests -----------------------------------------------------
  task automatic test_reset();
    nVectors++;
    if ({outValid, busy, outSum, outError} !== 18'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_outputs: got valid=%b busy=%b sum=%h err=%h, need all 0", outValid, busy, outSum, outError);
    end
    nVectors++;
    if ({mSumA, mErrA, mSumB, mErrB} !== 32'd0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_operands: got %h, need 0", {mSumA, mErrA, mSumB, mErrB});
    end
    rstN = 1'b1;
    @(negedge clk);
    nVectors++;
    if (inReady !== 1'b1 || busy !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_idle: got ready=%b busy=%b, need ready=1 busy=0", inReady, busy);
    end
  endtask

  task automatic test_single_pair();
    bit ok;
    gPairs[0] = {8'h3C, 8'h00};
    issuedQ.delete();
    applyStimulus(1, 1'b1, 0, ok);
    waitOutput(ok);
    nVectors++;
    if (!ok) begin
      nMiscompares++;
      $display("[TB] FAIL single_timeout: got out_valid=%b, need 1", outValid);
    end
    nVectors++;
    if ({outSum, outError} !== 16'h3C00) begin
      nMiscompares++;
      $display("[TB] FAIL single_data: got %h, need 3c00", {outSum, outError});
    end
    nVectors++;
    if (issuedQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL single_merges: got %0d, need 0", issuedQ.size());
    end
    acceptOutput(0);
  endtask

  task automatic test_four_ones();
    bit ok;
    for (int i = 0; i < 4; i++) gPairs[i] = {8'h3C, 8'h00};
    computeRef(4);
    issuedQ.delete();
    applyStimulus(4, 1'b1, 0, ok);
    waitOutput(ok);
    nVectors++;
    if (!ok || issuedQ.size() != 3) begin
      nMiscompares++;
      $display("[TB] FAIL four_merges: got valid=%b merges=%0d, need 1 and 3", outValid, issuedQ.size());
    end
    for (int i = 0; i < expIssues.size(); i++) begin
      nVectors++;
      if (i >= issuedQ.size() || issuedQ[i] !== expIssues[i]) begin
        nMiscompares++;
        $display("[TB] FAIL four_issue%0d: got %h, need %h", i, (i < issuedQ.size()) ? issuedQ[i] : 32'hx, expIssues[i]);
      end
    end
    nVectors++;
    if ({outSum, outError} !== 16'h4400) begin
      nMiscompares++;
      $display("[TB] FAIL four_data: got %h, need 4400", {outSum, outError});
    end
    acceptOutput(1);
  endtask

  task automatic test_fill_pool();
    bit ok;
    randomPairs(DEPTH);
    computeRef(DEPTH);
    issuedQ.delete();
    applyStimulus(DEPTH, 1'b0, 1, ok);
    nVectors++;
    if (!ok || inReady !== 1'b0 || busy !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL fill_ready: got ok=%b ready=%b busy=%b, need 1 0 1", ok, inReady, busy);
    end
    waitOutput(ok);
    nVectors++;
    if (!ok || issuedQ.size() != DEPTH - 1) begin
      nMiscompares++;
      $display("[TB] FAIL fill_merges: got valid=%b merges=%0d, need 1 and %0d", outValid, issuedQ.size(), DEPTH - 1);
    end
    for (int i = 0; i < expIssues.size(); i++) begin
      nVectors++;
      if (i >= issuedQ.size() || issuedQ[i] !== expIssues[i]) begin
        nMiscompares++;
        $display("[TB] FAIL fill_issue%0d: got %h, need %h", i, (i < issuedQ.size()) ? issuedQ[i] : 32'hx, expIssues[i]);
      end
    end
    nVectors++;
    if ({outSum, outError} !== expFinal) begin
      nMiscompares++;
      $display("[TB] FAIL fill_data: got %h, need %h", {outSum, outError}, expFinal);
    end
    acceptOutput(0);
  endtask

  task automatic test_out_hold();
    bit ok;
    randomPairs(3);
    computeRef(3);
    applyStimulus(3, 1'b1, 0, ok);
    waitOutput(ok);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nVectors++;
      if (outValid !== 1'b1 || {outSum, outError} !== expFinal) begin
        nMiscompares++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b data=%h, need 1 %h", c, outValid, {outSum, outError}, expFinal);
      end
    end
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    nVectors++;
    if (outValid !== 1'b0 || busy !== 1'b0 || inReady !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL hold_release: got valid=%b busy=%b ready=%b, need 0 0 1", outValid, busy, inReady);
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int cnt;
    randomPairs(4);
    issuedQ.delete();
    applyStimulus(4, 1'b1, 0, ok);
    cnt = 0;
    while (issuedQ.size() < 2 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    nVectors++;
    if (issuedQ.size() < 2) begin
      nMiscompares++;
      $display("[TB] FAIL midflight_issue: got %0d merges, need 2", issuedQ.size());
    end
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    nVectors++;
    if (busy !== 1'b0 || outValid !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL midflight_reset: got busy=%b valid=%b, need 0 0", busy, outValid);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    randomPairs(2);
    computeRef(2);
    issuedQ.delete();
    applyStimulus(2, 1'b1, 0, ok);
    waitOutput(ok);
    repeat (6) @(negedge clk);
    nVectors++;
    if (issuedQ.size() != 1 || issuedQ[0] !== expIssues[0]) begin
      nMiscompares++;
      $display("[TB] FAIL midflight_newissue: got n=%0d, need 1 op %h", issuedQ.size(), expIssues[0]);
    end
    nVectors++;
    if (outValid !== 1'b1 || {outSum, outError} !== expFinal) begin
      nMiscompares++;
      $display("[TB] FAIL midflight_data: got valid=%b data=%h, need 1 %h", outValid, {outSum, outError}, expFinal);
    end
    acceptOutput(0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sizes [2];
    sizes[0] = 5;
    sizes[1] = 2;
    for (int g = 0; g < 2; g++) begin
      randomPairs(sizes[g]);
      computeRef(sizes[g]);
      issuedQ.delete();
      applyStimulus(sizes[g], 1'b1, 0, ok);
      waitOutput(ok);
      nVectors++;
      if (!ok || issuedQ.size() != sizes[g] - 1 || {outSum, outError} !== expFinal) begin
        nMiscompares++;
        $display("[TB] FAIL b2b_group%0d: got valid=%b merges=%0d data=%h, need 1 %0d %h", g, outValid, issuedQ.size(), {outSum, outError}, sizes[g] - 1, expFinal);
      end
`ifdef FASTTWOSUM_SCHED_STATS_EN
      nVectors++;
      if (int'(mergeCount) != sizes[g] - 1) begin
        nMiscompares++;
        $display("[TB] FAIL b2b_merge_count%0d: got %0d, need %0d", g, mergeCount, sizes[g] - 1);
      end
`endif
      acceptOutput(0);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    bit markLast;
    for (int g = 0; g < 30; g++) begin
      n = int'($urandom_range(DEPTH, 1));
      markLast = (n < DEPTH) ? 1'b1 : 1'($urandom);
      randomPairs(n);
      computeRef(n);
      issuedQ.delete();
      applyStimulus(n, markLast, 2, ok);
      waitOutput(ok);
      nVectors++;
      if (!ok || issuedQ.size() != n - 1) begin
        nMiscompares++;
        $display("[TB] FAIL rand%0d_merges: got valid=%b merges=%0d, need 1 and %0d", g, outValid, issuedQ.size(), n - 1);
      end
      for (int i = 0; i < expIssues.size(); i++) begin
        nVectors++;
        if (i >= issuedQ.size() || issuedQ[i] !== expIssues[i]) begin
          nMiscompares++;
          $display("[TB] FAIL rand%0d_issue%0d: got %h, need %h", g, i, (i < issuedQ.size()) ? issuedQ[i] : 32'hx, expIssues[i]);
        end
      end
      nVectors++;
      if ({outSum, outError} !== expFinal) begin
        nMiscompares++;
        $display("[TB] FAIL rand%0d_data: got %h, need %h", g, {outSum, outError}, expFinal);
      end
      acceptOutput(int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    inValid  = 1'b0;
    inSum    = '0;
    inError  = '0;
    inLast   = 1'b0;
    outReady = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_pair();
    test_four_ones();
    test_fill_pool();
    test_out_hold();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/fasttwosum_merge_sched.md
# fasttwosum_merge_sched

Scheduler that reduces a variable-length group of (sum, error) pairs to one pair by time-sharing a single external `fasttwosum_merge` unit. It buffers incoming partial accumulations in a FIFO pool and issues the two oldest entries to the merge unit while at least two are available. Merge results are written back to the pool tail, and the final surviving pair is presented on a valid/ready output. It sits between the per-lane FastTwoSum accumulators and the downstream consumer.

## Interface
- `EXP_WIDTH_I`, 5: exponent width of the FP format.
- `MANT_WIDTH_I`, 2: mantissa width of the FP format.
- `DEPTH_I`, 8: pool capacity in pairs; must be a power of two and at least 2.
- `MERGE_LATENCY_I`, 3: cycles from issuing operands to a valid merge result.
- `BIT_WIDTH_I` (localparam): 1 + `EXP_WIDTH_I` + `MANT_WIDTH_I`.

Ports (W = `BIT_WIDTH_I`):
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1 / `in_ready_o` out 1: input handshake.
- `in_sum_i`, `in_error_i` in W: input pair.
- `in_last_i` in 1: marks the final pair of a group.
- `merge_sum_a_o`, `merge_error_a_o`, `merge_sum_b_o`, `merge_error_b_o` out W: operands driven to the merge unit.
- `merge_sum_i`, `merge_error_i` in W: merge unit result.
- `out_valid_o` out 1 / `out_ready_i` in 1: output handshake.
- `out_sum_o`, `out_error_o` out W: reduced pair.
- `busy_o` out 1: high in every state other than IDLE.

## Operation
- States:
  - IDLE: `in_ready_o`=1.
  - COLLECT: `in_ready_o`=1 while the pool is not full.
  - REDUCE: `in_ready_o`=0.
  - OUTPUT: `in_ready_o`=0, `out_valid_o`=1.
- A transfer occurs when `in_valid_i` and `in_ready_o` are both high. Each transfer pushes the pair to the pool tail.
- IDLE → COLLECT on the first transfer. If that transfer also has `in_last_i`=1, go directly to REDUCE.
- COLLECT → REDUCE on a transfer with `in_last_i`=1.
- The transfer that fills the pool (count reaches `DEPTH_I`) is treated as last, whatever the value of `in_last_i`.
- REDUCE, per cycle:
  - If pool count ≥ 2, pop the head into operand A and the next entry into operand B, drive them on the `merge_*_o` ports, and shift a 1 into the in-flight valid shift register (length `MERGE_LATENCY_I`).
  - Otherwise drive all operand outputs to 0 and shift in a 0.
- When the shift register outputs 1, `merge_sum_i`/`merge_error_i` are pushed to the pool tail in that cycle.
- Simultaneous pop-2 and push-1 in one cycle: count changes by −1. The pop reads the pre-push contents.
- Order is strictly FIFO (oldest pair first, result to the tail). This fixes the association order, so results are bit-reproducible.
- REDUCE → OUTPUT when count == 1 and no ops are in flight. The remaining entry is registered into `out_sum_o`/`out_error_o`.
- A group of exactly one pair passes through unmerged.
- OUTPUT → IDLE on `out_valid_o` && `out_ready_i`. Output data is held stable while `out_ready_i`=0.
- The pool never overflows in REDUCE: each merge frees one net entry.

## Timing
- Reset values: all outputs 0, state IDLE, pool empty, in-flight register cleared.
- Reset mid-operation discards the group. Merge results still in flight are ignored because the valid shift register is cleared.
- First issue occurs in the cycle after entering REDUCE.
- Result of an op issued at cycle t is pushed at cycle t+`MERGE_LATENCY_I`.
- With G pairs, G−1 merges are performed.
- `out_valid_o` rises at the earliest one cycle after the last result push.
- `in_ready_o` is registered-state-based with no combinational path from `in_valid_i`.

## Configuration
- `FASTTWOSUM_SCHED_STATS_EN` defined:
  - Adds output `merge_count_o` ($clog2(`DEPTH_I`)+1 bits), the number of merges issued for the current group.
  - Adds output `cycle_count_o` (16 bits, saturating), the cycles spent in REDUCE.
  - Both are cleared on IDLE → COLLECT and on reset, and hold their values during OUTPUT.
- Not defined: neither port nor its counters exist.

## Structure
- Package `fasttwosum_pkg` holds:
  - The state enum `sched_state_e`.
  - The struct `fp_pair_t` {sum, error}, parameterised via package-level width localparams or a typedef macro.
- Sub-module `fasttwosum_pair_pool`:
  - Circular FIFO with one push and up to two pops per cycle.
  - Head/tail pointers and count.
  - Outputs `head0`/`head1`.

## Test plan
All values are E5M2 (defaults), with a behavioural 3-cycle merge model.
- Single pair: push (0x3C, 0x00) with `in_last_i`=1 → output (0x3C, 0x00), zero merges issued.
- Four pairs of 1.0 (0x3C) with last on the 4th → issue order (p0,p1), (p2,p3), (r01,r23). Output sum 0x44 (4.0), error 0x00. Exactly 3 merges.
- Push `DEPTH_I`=8 pairs without `in_last_i` → `in_ready_o`=0 after the 8th transfer, REDUCE entered, 7 merges issued.
- Hold `out_ready_i`=0 for 5 cycles in OUTPUT → `out_valid_o` and data stable. Then return to IDLE one cycle after the handshake.
- Assert `rst_ni`=0 with 2 ops in flight, then release and run a new 2-pair group → stale results are never pushed, and the output equals the new group's merge only.
- `FASTTWOSUM_SCHED_STATS_EN` defined, 5-pair group → `merge_count_o`=4.
